// File: rtl/c3d_pll_seq_pkg.sv
// c3d_pll_seq_pkg: shared types and constants for the two-PLL reset/lock sequencer.
package c3d_pll_seq_pkg;

  // Sequencer states; the encodings are visible on the debug STATE port.
  typedef enum logic [2:0] {
    S_RESET_PLL0 = 3'd0,
    S_WAIT_LOCK0 = 3'd1,
    S_RESET_PLL1 = 3'd2,
    S_WAIT_LOCK1 = 3'd3,
    S_RELEASE    = 3'd4,
    S_RUN        = 3'd5,
    S_FAILED     = 3'd6
  } pll_state_e;

  // Width of the per-PLL retry counter.
  localparam int RETRY_W = 3;

endpackage

// File: rtl/c3d_sync2.sv
// c3d_sync2: two-flop synchronizer for an asynchronous level input (latency 2).
module c3d_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  // Two back-to-back flops resolve metastability before the value is used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/c3d_pll_seq.sv
// c3d_pll_seq: brings PLL0 then PLL1 out of reset, qualifies each LOCKED for
// stability, retries on lock timeout and releases the system and memory
// domain resets in order. Runs on the free-running reference clock.
// Optional macro C3D_PLL_SEQ_LOCKMON_EN enables loss-of-lock monitoring in
// RUN; without it RUN is terminal until RESTART or rst_n.
module c3d_pll_seq
  import c3d_pll_seq_pkg::*;
#(
  parameter int RST_HOLD_CYC     = 64,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int MAX_RETRY        = 7,
  parameter int MEM_DELAY_CYC    = 16,
  parameter int CNT_W            = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll0_lock,
  input  logic               pll1_lock,
  input  logic               restart,
  output logic               pll0_rst,
  output logic               pll1_rst,
  output logic               sys_rst_n,
  output logic               mem_rst_n,
  output logic               ready,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [2:0]         state
);

  localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]   MEM_LAST     = CNT_W'(MEM_DELAY_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);
  localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);

  logic lock0_s;
  logic lock1_s;

  pll_state_e         state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [CNT_W-1:0]   stable_reg;
  logic [RETRY_W-1:0] retry_reg;
  logic               fail_reg;
  logic               started_reg;
  logic               pll0_rst_reg;
  logic               pll1_rst_reg;
  logic               sys_rst_n_reg;
  logic               mem_rst_n_reg;
  logic               ready_reg;

  c3d_sync2 u_sync_lock0 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll0_lock),
    .q     (lock0_s)
  );

  c3d_sync2 u_sync_lock1 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll1_lock),
    .q     (lock1_s)
  );

  // Sequencer FSM with registered outputs. sys_rst_n is only written where it
  // must change, so a re-lock of PLL1 entered from RUN keeps the system domain
  // out of reset while the memory domain is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_RESET_PLL0;
      cnt_reg       <= '0;
      stable_reg    <= '0;
      retry_reg     <= '0;
      fail_reg      <= 1'b0;
      started_reg   <= 1'b0;
      pll0_rst_reg  <= 1'b1;
      pll1_rst_reg  <= 1'b1;
      sys_rst_n_reg <= 1'b0;
      mem_rst_n_reg <= 1'b0;
      ready_reg     <= 1'b0;
    end else if (restart || !started_reg) begin
      // The first edge after reset release is treated as the entry edge of
      // RESET_PLL0, so the PLL reset is held for the full hold time after
      // rst_n rises; RESTART takes the identical path.
      state_reg     <= S_RESET_PLL0;
      cnt_reg       <= '0;
      stable_reg    <= '0;
      retry_reg     <= '0;
      fail_reg      <= 1'b0;
      started_reg   <= 1'b1;
      pll0_rst_reg  <= 1'b1;
      pll1_rst_reg  <= 1'b1;
      sys_rst_n_reg <= 1'b0;
      mem_rst_n_reg <= 1'b0;
      ready_reg     <= 1'b0;
    end else begin
      case (state_reg)
        S_RESET_PLL0: begin
          if (cnt_reg == HOLD_LAST) begin
            state_reg    <= S_WAIT_LOCK0;
            cnt_reg      <= '0;
            stable_reg   <= '0;
            pll0_rst_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        S_WAIT_LOCK0: begin
          if (lock0_s && stable_reg == STABLE_LAST) begin
            state_reg    <= S_RESET_PLL1;
            cnt_reg      <= '0;
            stable_reg   <= '0;
            retry_reg    <= '0;
            pll1_rst_reg <= 1'b1;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            cnt_reg    <= '0;
            stable_reg <= '0;
            if (retry_reg < RETRY_MAX) begin
              state_reg    <= S_RESET_PLL0;
              retry_reg    <= retry_reg + 1'b1;
              pll0_rst_reg <= 1'b1;
            end else begin
              state_reg    <= S_FAILED;
              fail_reg     <= 1'b1;
              pll0_rst_reg <= 1'b1;
              pll1_rst_reg <= 1'b1;
            end
          end else begin
            cnt_reg    <= cnt_reg + CNT_ONE;
            stable_reg <= lock0_s ? stable_reg + CNT_ONE : '0;
          end
        end

        S_RESET_PLL1: begin
          pll0_rst_reg <= 1'b0;
          if (cnt_reg == HOLD_LAST) begin
            state_reg    <= S_WAIT_LOCK1;
            cnt_reg      <= '0;
            stable_reg   <= '0;
            pll1_rst_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        S_WAIT_LOCK1: begin
          if (lock1_s && stable_reg == STABLE_LAST) begin
            state_reg     <= S_RELEASE;
            cnt_reg       <= '0;
            stable_reg    <= '0;
            retry_reg     <= '0;
            sys_rst_n_reg <= 1'b1;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            cnt_reg    <= '0;
            stable_reg <= '0;
            if (retry_reg < RETRY_MAX) begin
              state_reg    <= S_RESET_PLL1;
              retry_reg    <= retry_reg + 1'b1;
              pll1_rst_reg <= 1'b1;
            end else begin
              state_reg     <= S_FAILED;
              fail_reg      <= 1'b1;
              pll0_rst_reg  <= 1'b1;
              pll1_rst_reg  <= 1'b1;
              sys_rst_n_reg <= 1'b0;
              mem_rst_n_reg <= 1'b0;
            end
          end else begin
            cnt_reg    <= cnt_reg + CNT_ONE;
            stable_reg <= lock1_s ? stable_reg + CNT_ONE : '0;
          end
        end

        S_RELEASE: begin
          sys_rst_n_reg <= 1'b1;
          if (cnt_reg == MEM_LAST) begin
            state_reg     <= S_RUN;
            cnt_reg       <= '0;
            mem_rst_n_reg <= 1'b1;
            ready_reg     <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        S_RUN: begin
          retry_reg <= '0;
`ifdef C3D_PLL_SEQ_LOCKMON_EN
          // Losing PLL0 takes everything down; losing only PLL1 holds just
          // the memory domain while PLL1 is re-sequenced.
          if (!lock0_s) begin
            state_reg     <= S_RESET_PLL0;
            cnt_reg       <= '0;
            stable_reg    <= '0;
            pll0_rst_reg  <= 1'b1;
            pll1_rst_reg  <= 1'b1;
            sys_rst_n_reg <= 1'b0;
            mem_rst_n_reg <= 1'b0;
            ready_reg     <= 1'b0;
          end else if (!lock1_s) begin
            state_reg     <= S_RESET_PLL1;
            cnt_reg       <= '0;
            stable_reg    <= '0;
            pll1_rst_reg  <= 1'b1;
            mem_rst_n_reg <= 1'b0;
            ready_reg     <= 1'b0;
          end
`endif
        end

        S_FAILED: begin
          fail_reg      <= 1'b1;
          pll0_rst_reg  <= 1'b1;
          pll1_rst_reg  <= 1'b1;
          sys_rst_n_reg <= 1'b0;
          mem_rst_n_reg <= 1'b0;
          ready_reg     <= 1'b0;
        end

        default: begin
          state_reg     <= S_RESET_PLL0;
          cnt_reg       <= '0;
          stable_reg    <= '0;
          pll0_rst_reg  <= 1'b1;
          pll1_rst_reg  <= 1'b1;
          sys_rst_n_reg <= 1'b0;
          mem_rst_n_reg <= 1'b0;
          ready_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign pll0_rst  = pll0_rst_reg;
  assign pll1_rst  = pll1_rst_reg;
  assign sys_rst_n = sys_rst_n_reg;
  assign mem_rst_n = mem_rst_n_reg;
  assign ready     = ready_reg;
  assign fail      = fail_reg;
  assign retry_cnt = retry_reg;
  assign state     = state_reg;

endmodule

// File: tb/tb_c3d_pll_seq.sv
// tb_c3d_pll_seq: directed bench for c3d_pll_seq with shortened timing
// (hold 4, stable 8, timeout 32, max retry 2, memory delay 3).
module tb_c3d_pll_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll0_lock = 1'b1;
  logic       pll1_lock = 1'b1;
  logic       restart = 1'b0;
  logic       pll0_rst;
  logic       pll1_rst;
  logic       sys_rst_n;
  logic       mem_rst_n;
  logic       ready;
  logic       fail;
  logic [2:0] retry_cnt;
  logic [2:0] state;

  int total = 0;
  int bad = 0;
  int cur_edge = -1;

  c3d_pll_seq #(
    .RST_HOLD_CYC     (4),
    .LOCK_STABLE_CYC  (8),
    .LOCK_TIMEOUT_CYC (32),
    .MAX_RETRY        (2),
    .MEM_DELAY_CYC    (3),
    .CNT_W            (17)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll0_lock (pll0_lock),
    .pll1_lock (pll1_lock),
    .restart   (restart),
    .pll0_rst  (pll0_rst),
    .pll1_rst  (pll1_rst),
    .sys_rst_n (sys_rst_n),
    .mem_rst_n (mem_rst_n),
    .ready     (ready),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-14s edge=%0d observed=%0d expected=%0d", tag, cur_edge, obs, exp);
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    cur_edge++;
  endtask

  task automatic goto_edge(input int e);
    while (cur_edge < e) tick();
  endtask

  // Release reset so that the next rising edge is edge 0.
  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cur_edge = -1;
  endtask

  task automatic check_reset_values(input string sfx);
    check({"rst_pll0_", sfx}, pll0_rst, 1);
    check({"rst_pll1_", sfx}, pll1_rst, 1);
    check({"rst_sys_", sfx}, sys_rst_n, 0);
    check({"rst_mem_", sfx}, mem_rst_n, 0);
    check({"rst_ready_", sfx}, ready, 0);
    check({"rst_fail_", sfx}, fail, 0);
    check({"rst_retry_", sfx}, retry_cnt, 0);
    check({"rst_state_", sfx}, state, 0);
  endtask

  initial begin
    // ---------------- Nominal bring-up, locks tied high ----------------
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("init");
    release_reset();
    goto_edge(3);  check("pll0_rst_e3", pll0_rst, 1);
    goto_edge(4);  check("pll0_rst_e4", pll0_rst, 0);
                   check("state_e4", state, 1);
                   check("pll1_rst_e4", pll1_rst, 1);
    goto_edge(12); check("state_e12", state, 2);
    goto_edge(15); check("pll1_rst_e15", pll1_rst, 1);
    goto_edge(16); check("pll1_rst_e16", pll1_rst, 0);
                   check("state_e16", state, 3);
    goto_edge(23); check("sys_e23", sys_rst_n, 0);
    goto_edge(24); check("sys_e24", sys_rst_n, 1);
                   check("mem_e24", mem_rst_n, 0);
                   check("state_e24", state, 4);
    goto_edge(26); check("mem_e26", mem_rst_n, 0);
                   check("ready_e26", ready, 0);
    goto_edge(27); check("mem_e27", mem_rst_n, 1);
                   check("ready_e27", ready, 1);
                   check("state_e27", state, 5);

`ifdef C3D_PLL_SEQ_LOCKMON_EN
    // ---------------- PLL1 loss of lock in RUN ----------------
    goto_edge(30); pll1_lock = 1'b0;
    goto_edge(32); check("mem_l1_e32", mem_rst_n, 1);
    goto_edge(33); check("mem_l1_e33", mem_rst_n, 0);
                   check("ready_l1_e33", ready, 0);
                   check("sys_l1_e33", sys_rst_n, 1);
                   check("state_l1_e33", state, 2);
    goto_edge(34); pll1_lock = 1'b1;
    goto_edge(37); check("state_l1_e37", state, 3);
                   check("sys_l1_e37", sys_rst_n, 1);
    goto_edge(45); check("state_l1_e45", state, 4);
    goto_edge(47); check("ready_l1_e47", ready, 0);
    goto_edge(48); check("ready_l1_e48", ready, 1);
                   check("mem_l1_e48", mem_rst_n, 1);
    // ---------------- Both locks lost together ----------------
    goto_edge(50); pll0_lock = 1'b0; pll1_lock = 1'b0;
    goto_edge(52); check("ready_both_e52", ready, 1);
    goto_edge(53); check("sys_both_e53", sys_rst_n, 0);
                   check("mem_both_e53", mem_rst_n, 0);
                   check("ready_both_e53", ready, 0);
                   check("state_both_e53", state, 0);
                   check("pll0_both_e53", pll0_rst, 1);
`else
    // ---------------- RUN is terminal without monitoring ----------------
    goto_edge(30); pll0_lock = 1'b0;
    goto_edge(40); check("ready_nomon", ready, 1);
                   check("state_nomon", state, 5);
                   check("sys_nomon", sys_rst_n, 1);
                   check("mem_nomon", mem_rst_n, 1);
`endif

    // ---------------- Asynchronous reset mid-sequence ----------------
    rst_n = 1'b0;
    pll0_lock = 1'b0;
    pll1_lock = 1'b1;
    #1;
    check_reset_values("async");

    // ---------------- PLL0 never locks: retries then FAILED ----------------
    release_reset();
    goto_edge(35);  check("retry_e35", retry_cnt, 0);
    goto_edge(36);  check("retry_e36", retry_cnt, 1);
                    check("state_e36", state, 0);
    goto_edge(72);  check("retry_e72", retry_cnt, 2);
    goto_edge(107); check("fail_e107", fail, 0);
                    check("state_e107", state, 1);
    goto_edge(108); check("fail_e108", fail, 1);
                    check("state_e108", state, 6);
                    check("pll0_e108", pll0_rst, 1);
                    check("pll1_e108", pll1_rst, 1);
    goto_edge(110); check("fail_e110", fail, 1);
    restart = 1'b1;
    goto_edge(111); restart = 1'b0;
                    check("state_rs", state, 0);
                    check("fail_rs", fail, 0);
                    check("retry_rs", retry_cnt, 0);

    // ---------------- PLL1 lock glitch inside stable window ----------------
    rst_n = 1'b0;
    pll0_lock = 1'b1;
    pll1_lock = 1'b1;
    #1;
    release_reset();
    goto_edge(19); pll1_lock = 1'b0;
    goto_edge(20); pll1_lock = 1'b1;
    goto_edge(24); check("sys_gl_e24", sys_rst_n, 0);
                   check("state_gl_e24", state, 3);
    goto_edge(29); check("sys_gl_e29", sys_rst_n, 0);
    goto_edge(30); check("sys_gl_e30", sys_rst_n, 1);
                   check("state_gl_e30", state, 4);
    goto_edge(32); check("ready_gl_e32", ready, 0);
    goto_edge(33); check("ready_gl_e33", ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
